sdram_arb_mux: RTL and testbench
================================

SDRAM_ARB_MUX -- requirements
Module: sdram_arb_mux

Interface
REQ-001 SHALL have parameter N, default 2: number of requesting channels, legal range 2..8.
REQ-002 SHALL have parameter AW, default 24: address width.
REQ-003 SHALL have parameter DW, default 16: data width.
REQ-004 SHALL have parameter TAGD, default 4: read-tag FIFO depth, power of two, legal range 2..16.
REQ-005 SHALL have parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with channel 0 highest.
REQ-006 SHALL have parameter STARVE_CYC, default 255: wait-cycle threshold for the starvation flag.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all state updated on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-009 SHALL have port req, input, N bits: per-channel request; the channel holds it high until its ack.
REQ-010 SHALL have port we, input, N bits: per-channel write (1) or read (0).
REQ-011 SHALL have port addr, input, N x AW: per-channel address.
REQ-012 SHALL have port wdata, input, N x DW: per-channel write data.
REQ-013 SHALL have port ack, output, N bits: per-channel acceptance strobe.
REQ-014 SHALL have port rvalid, output, N bits: per-channel read-return strobe.
REQ-015 SHALL have port rdata, output, DW: read data broadcast to all channels.
REQ-016 SHALL have ports if_req (output, 1), if_we (output, 1), if_addr (output, AW), if_data (output, DW): controller command side.
REQ-017 SHALL have port if_rdy, input, 1 bit: the controller accepts the command this cycle.
REQ-018 SHALL have ports if_rvalid (input, 1) and if_rdata (input, DW): controller read return, in command order.
REQ-019 SHALL have port tag_err, output, 1 bit: sticky flag, set by a read return with no outstanding tag.
REQ-020 SHALL have port starve, output, N bits: per-channel starvation flag.

Function
REQ-021 SHALL implement two states: IDLE and ISSUE.
REQ-022 IDLE: when any eligible req is high, SHALL pick a winner, register its we/addr/wdata into if_we/if_addr/if_data, set sel, and enter ISSUE next cycle.
- Eligible: req high, and either a write or tag FIFO count < TAGD.
REQ-023 RR=1: SHALL search from ptr upward modulo N; after each acceptance, ptr = sel+1 (wrapping from N-1 to 0).
REQ-024 RR=0: SHALL grant the lowest eligible index.
REQ-025 if_req SHALL equal (state==ISSUE); if_we/if_addr/if_data SHALL be stable throughout ISSUE.
REQ-026 Acceptance SHALL be the cycle with if_req & if_rdy.
- ack[sel] asserted combinationally in that cycle only.
- Next state IDLE.
- If a read, sel pushed into the tag FIFO.
REQ-027 Minimum spacing between consecutive acceptances SHALL be 2 cycles (one IDLE bubble); req sampled at edge k gives earliest if_req at cycle k+1.
REQ-028 if_rvalid SHALL pop the tag FIFO and assert rvalid[head] in the same cycle; rdata SHALL equal if_rdata combinationally.
REQ-029 Simultaneous push and pop SHALL leave the count unchanged.
REQ-030 A push when count==TAGD is impossible by REQ-022 eligibility.
REQ-031 if_rvalid with an empty FIFO SHALL assert no rvalid bit and SHALL set tag_err.
REQ-032 tag_err SHALL clear only on reset.
REQ-033 The tag FIFO pointers SHALL wrap modulo TAGD.
REQ-034 A channel dropping req before its ack is a protocol violation; the latched command still completes and the ack is still issued.

Reset
REQ-035 While reset is high at a clock edge, SHALL force:
- state=IDLE, ptr=0, sel=0;
- FIFO empty;
- tag_err=0, starve=0, starvation counters 0;
- if_req=0, if_we=0, if_addr=0, if_data=0.
REQ-036 ack and rvalid SHALL be 0 while reset is high.
REQ-037 Reset mid-ISSUE SHALL abandon the command without ack; outstanding tags SHALL be discarded.

Configuration
REQ-038 Macro SDRAM_ARB_STARVE_EN defined: per-channel 16-bit saturating counter that increments while req high and no ack, and clears on ack; starve[i] = counter >= STARVE_CYC.
REQ-039 Macro SDRAM_ARB_STARVE_EN undefined: no counters are built; starve is tied to 0.

Verification
REQ-040 N=2, RR=1, both req held, if_rdy=1 -> ack order 0,1,0,1, acceptances on every second cycle.
REQ-041 N=4, RR=0, req=4'b1110 held, if_rdy=1 -> channel 1 granted repeatedly; starve[3]=1 after 255 cycles when SDRAM_ARB_STARVE_EN is defined, 0 when undefined.
REQ-042 TAGD=4, channel 0 issues 5 reads, no if_rvalid -> 4 acks, then if_req stays 0; a channel-1 write is still accepted; one if_rvalid -> 5th read issued.
REQ-043 Reads from ch2, ch0, ch2 accepted; returns 16'hA1, 16'hB2, 16'hC3 -> rvalid[2] with A1, rvalid[0] with B2, rvalid[2] with C3.
REQ-044 if_rvalid with an empty FIFO -> no rvalid, tag_err=1 until reset.
REQ-045 Reset asserted during ISSUE with if_rdy=0 -> next cycle if_req=0, no ack, FIFO count 0, ptr=0.

Source files
------------

// File: rtl/sdram_arb_mux.sv
// sdram_arb_mux: N-channel command arbiter/mux for an SDRAM controller with in-order read-tag return.
// Define SDRAM_ARB_STARVE_EN to build the per-channel starvation counters.
module sdram_arb_mux #(
    parameter int N          = 2,
    parameter int AW         = 24,
    parameter int DW         = 16,
    parameter int TAGD       = 4,
    parameter int RR         = 1,
    parameter int STARVE_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         we,
    input  logic [N-1:0][AW-1:0] addr,
    input  logic [N-1:0][DW-1:0] wdata,
    output logic [N-1:0]         ack,
    output logic [N-1:0]         rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 if_req,
    output logic                 if_we,
    output logic [AW-1:0]        if_addr,
    output logic [DW-1:0]        if_data,
    input  logic                 if_rdy,
    input  logic                 if_rvalid,
    input  logic [DW-1:0]        if_rdata,
    output logic                 tag_err,
    output logic [N-1:0]         starve
);
    localparam int SW = $clog2(N);
    localparam int PW = $clog2(TAGD);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(TAGD);

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t r_state, w_next;

    logic [SW-1:0] r_ptr, r_sel, w_win, w_base;
    logic [N-1:0]  w_elig;
    logic          w_any, w_accept, w_push, w_pop;
    logic          r_if_we;
    logic [AW-1:0] r_if_addr;
    logic [DW-1:0] r_if_data;
    logic [SW-1:0] r_tag [TAGD];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_tag_err;

    function automatic logic [SW-1:0] wrap(input logic [SW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return SW'((s >= N) ? s - N : s);
    endfunction

    // A read may only be latched while a tag slot is free, so the FIFO can never overflow.
    assign w_elig = req & (we | {N{r_cnt < FULL}});
    assign w_any  = |w_elig;
    assign w_base = (RR != 0) ? r_ptr : '0;

    // Scan from the highest offset down so the nearest eligible channel to the base wins.
    always_comb begin
        w_win = '0;
        for (int k = N - 1; k >= 0; k--)
            if (w_elig[wrap(w_base, k)]) w_win = wrap(w_base, k);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_any ? ISSUE : IDLE) : (if_rdy ? IDLE : ISSUE);
    end

    always_comb begin
        if_req     = (r_state == ISSUE);
        w_accept   = if_req & if_rdy & ~reset;
        ack        = '0;
        ack[r_sel] = w_accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= '0;
            r_sel     <= '0;
            r_if_we   <= 1'b0;
            r_if_addr <= '0;
            r_if_data <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_sel     <= w_win;
                r_if_we   <= we[w_win];
                r_if_addr <= addr[w_win];
                r_if_data <= wdata[w_win];
            end
            if (w_accept && RR != 0) r_ptr <= (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;
        end
    end

    assign if_we   = r_if_we;
    assign if_addr = r_if_addr;
    assign if_data = r_if_data;

    assign w_push  = w_accept & ~r_if_we;
    assign w_pop   = if_rvalid & (r_cnt != '0) & ~reset;
    assign rdata   = if_rdata;
    assign tag_err = r_tag_err;

    always_comb begin
        rvalid              = '0;
        rvalid[r_tag[r_rp]] = w_pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_tag_err <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (if_rvalid && r_cnt == '0) r_tag_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_tag[r_wp] <= r_sel;
    end

`ifdef SDRAM_ARB_STARVE_EN
    localparam logic [15:0] THR = 16'(STARVE_CYC);
    logic [15:0] r_scnt [N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (reset || ack[i]) r_scnt[i] <= '0;
            else if (req[i] && r_scnt[i] != 16'hFFFF) r_scnt[i] <= r_scnt[i] + 1'b1;
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < N; i++) starve[i] = (r_scnt[i] >= THR);
    end
`else
    assign starve = '0;
`endif
endmodule

// File: tb/tb_sdram_arb_mux.sv
// tb_sdram_arb_mux: directed bench; instance a is N=2 round-robin, instance b is N=4 fixed priority.
module tb_sdram_arb_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

`ifdef SDRAM_ARB_STARVE_EN
    localparam logic [3:0] STV = 4'b1100;
`else
    localparam logic [3:0] STV = 4'b0000;
`endif

    logic              a_rst, a_rdy, a_rv, a_ifreq, a_ifwe, a_err;
    logic [1:0]        a_req, a_we, a_ack, a_rvalid, a_starve;
    logic [1:0][23:0]  a_addr;
    logic [1:0][15:0]  a_wdata;
    logic [15:0]       a_rd, a_rdata, a_ifdata;
    logic [23:0]       a_ifaddr;

    logic              b_rst, b_rdy, b_rv, b_ifreq, b_ifwe, b_err;
    logic [3:0]        b_req, b_we, b_ack, b_rvalid, b_starve;
    logic [3:0][23:0]  b_addr;
    logic [3:0][15:0]  b_wdata;
    logic [15:0]       b_rd, b_rdata, b_ifdata;
    logic [23:0]       b_ifaddr;

    sdram_arb_mux #(.N(2), .RR(1)) u_a (
        .clk(clk), .reset(a_rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
        .ack(a_ack), .rvalid(a_rvalid), .rdata(a_rdata), .if_req(a_ifreq), .if_we(a_ifwe),
        .if_addr(a_ifaddr), .if_data(a_ifdata), .if_rdy(a_rdy), .if_rvalid(a_rv),
        .if_rdata(a_rd), .tag_err(a_err), .starve(a_starve)
    );

    sdram_arb_mux #(.N(4), .RR(0), .TAGD(4)) u_b (
        .clk(clk), .reset(b_rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
        .ack(b_ack), .rvalid(b_rvalid), .rdata(b_rdata), .if_req(b_ifreq), .if_we(b_ifwe),
        .if_addr(b_ifaddr), .if_data(b_ifdata), .if_rdy(b_rdy), .if_rvalid(b_rv),
        .if_rdata(b_rd), .tag_err(b_err), .starve(b_starve)
    );

    typedef struct packed {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  we;
        logic        rdy;
        logic        rv;
        logic [15:0] rd;
        logic [1:0]  ack;
        logic        ifreq;
        logic        ifwe;
        logic [23:0] addr;
        logic [1:0]  rvl;
        logic        err;
    } vec_t;

    vec_t        tbl [17];
    logic [15:0] rvals [3];
    logic [3:0]  rexp [3];
    int          cnt [4];
    bit          hit;
    logic [1:0]  got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_a(input int ch, output bit h);
        h = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_ack[ch]) begin
                h = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_b(input int ch, output bit h);
        h = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b_ack[ch]) begin
                h = 1'b1;
                break;
            end
        end
    endtask

    task automatic reset_b();
        @(posedge clk); #1;
        b_rst = 1'b1; b_req = '0; b_we = '0; b_rv = 1'b0;
        @(posedge clk); #1;
        b_rst = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_req = '0; a_we = '0; a_rdy = 1'b0; a_rv = 1'b0; a_rd = '0;
        a_addr[0] = 24'h000100; a_addr[1] = 24'h000200;
        a_wdata[0] = 16'h1111;  a_wdata[1] = 16'h2222;
        b_rst = 1'b1; b_req = '0; b_we = '0; b_rdy = 1'b0; b_rv = 1'b0; b_rd = '0;
        for (int i = 0; i < 4; i++) begin
            b_addr[i]  = 24'h001000 + 24'(i);
            b_wdata[i] = 16'h5000 + 16'(i);
        end
        rvals = '{16'hA1, 16'hB2, 16'hC3};
        rexp  = '{4'b0100, 4'b0001, 4'b0100};
        //            rst  req    we     rdy   rv    rd        ack    ifreq ifwe  addr         rvl    err
        tbl[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b1, 24'h000100, 2'b00, 1'b0};
        tbl[3]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 24'h000100, 2'b00, 1'b0};
        tbl[4]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b10, 1'b1, 1'b1, 24'h000200, 2'b00, 1'b0};
        tbl[5]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 24'h000200, 2'b00, 1'b0};
        tbl[6]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b1, 24'h000100, 2'b00, 1'b0};
        tbl[7]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 24'h000100, 2'b00, 1'b0};
        tbl[8]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 16'h0000, 2'b10, 1'b1, 1'b1, 24'h000200, 2'b00, 1'b0};
        tbl[9]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 24'h000200, 2'b00, 1'b0};
        tbl[10] = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 24'h000100, 2'b00, 1'b0};
        tbl[11] = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b0, 24'h000100, 2'b00, 1'b0};
        tbl[12] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 16'h00A1, 2'b00, 1'b0, 1'b0, 24'h000100, 2'b01, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0055, 2'b00, 1'b0, 1'b0, 24'h000100, 2'b00, 1'b0};
        tbl[14] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 24'h000100, 2'b00, 1'b1};
        tbl[15] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 24'h000100, 2'b00, 1'b1};
        tbl[16] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00, 1'b0};

        repeat (2) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            a_rst = tbl[i].rst; a_req = tbl[i].req; a_we = tbl[i].we;
            a_rdy = tbl[i].rdy; a_rv = tbl[i].rv;   a_rd = tbl[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {a_ack, a_ifreq, a_ifwe, a_ifaddr, a_rvalid, a_rdata, a_err},
                {tbl[i].ack, tbl[i].ifreq, tbl[i].ifwe, tbl[i].addr, tbl[i].rvl, tbl[i].rd, tbl[i].err});
        end

        // Reset while a command is held in ISSUE, with one read tag outstanding.
        @(posedge clk); #1;
        a_req = 2'b01; a_we = 2'b00; a_rdy = 1'b1;
        wait_a(0, hit);
        chk("a_read_ack", hit, 1);
        a_req = 2'b00;
        @(posedge clk); #1;
        a_req = 2'b10; a_we = 2'b10; a_rdy = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_ifreq) begin
                hit = 1'b1;
                break;
            end
        end
        chk("a_issue_hold", hit, 1);
        @(posedge clk); #1;
        a_rst = 1'b1;
        @(negedge clk);
        chk("a_rst_cycle_ack", a_ack, 0);
        @(posedge clk); #1;
        a_rst = 1'b0; a_req = 2'b00;
        @(negedge clk);
        chk("a_rst_ifreq_ack", {a_ifreq, a_ack}, 0);
        @(posedge clk); #1;
        a_rv = 1'b1; a_rd = 16'h7777;
        @(negedge clk);
        chk("a_rst_fifo_empty", a_rvalid, 0);
        @(posedge clk); #1;
        a_rv = 1'b0;
        @(negedge clk);
        chk("a_rst_tag_err", a_err, 1);
        @(posedge clk); #1;
        a_req = 2'b11; a_we = 2'b11; a_rdy = 1'b1;
        got = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_ack != 0) begin
                got = a_ack;
                break;
            end
        end
        chk("a_rst_ptr", got, 2'b01);
        a_req = 2'b00;

        // Fixed priority with channel 1 always winning; 2 and 3 starve.
        @(posedge clk); #1;
        b_rst = 1'b0; b_req = 4'b1110; b_we = 4'b1110; b_rdy = 1'b1;
        cnt = '{0, 0, 0, 0};
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (b_ack[k]) cnt[k]++;
        end
        chk("b_starve_early", b_starve, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (b_ack[k]) cnt[k]++;
        end
        chk("b_starve_late", b_starve, STV);
        chk("b_ack_ch1_count", cnt[1], 135);
        chk("b_ack_others", cnt[0] + cnt[2] + cnt[3], 0);
        reset_b();
        @(negedge clk);
        chk("b_starve_reset", b_starve, 0);

        // Tag FIFO full: reads blocked, writes still flow, one return frees a slot.
        @(posedge clk); #1;
        b_req = 4'b0001; b_we = 4'b0000; b_rdy = 1'b1;
        cnt[0] = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b_ack[0]) cnt[0]++;
        end
        chk("b_full_acks", cnt[0], 4);
        chk("b_full_ifreq", b_ifreq, 0);
        b_req = 4'b0011; b_we = 4'b0010;
        wait_b(1, hit);
        chk("b_write_while_full", hit, 1);
        b_req = 4'b0001; b_we = 4'b0000;
        @(posedge clk); #1;
        b_rv = 1'b1; b_rd = 16'h1234;
        @(negedge clk);
        chk("b_pop_rvalid", {b_rvalid, b_rdata}, {4'b0001, 16'h1234});
        @(posedge clk); #1;
        b_rv = 1'b0;
        wait_b(0, hit);
        chk("b_fifth_read", hit, 1);
        reset_b();

        // In-order return routing: reads from ch2, ch0, ch2.
        b_req = 4'b0100; b_we = 4'b0000; b_rdy = 1'b1;
        wait_b(2, hit);
        chk("b_rd_ch2_a", hit, 1);
        b_req = 4'b0001;
        wait_b(0, hit);
        chk("b_rd_ch0", hit, 1);
        b_req = 4'b0100;
        wait_b(2, hit);
        chk("b_rd_ch2_b", hit, 1);
        b_req = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            b_rv = 1'b1; b_rd = rvals[j];
            @(negedge clk);
            chk($sformatf("b_return%0d", j), {b_rvalid, b_rdata}, {rexp[j], rvals[j]});
        end

        // Return with nothing outstanding: no strobe, sticky error until reset.
        @(posedge clk); #1;
        b_rd = 16'hDEAD;
        @(negedge clk);
        chk("b_empty_return", {b_rvalid, b_err}, 0);
        @(posedge clk); #1;
        b_rv = 1'b0;
        @(negedge clk);
        chk("b_tag_err_set", b_err, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("b_tag_err_sticky", b_err, 1);
        reset_b();
        @(negedge clk);
        chk("b_tag_err_clear", b_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
